// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   - state_t : FSM encoding (IDLE/RUN/DONE), STATE_W bits wide
//   - magnitude() : two's-complement magnitude of a w-bit value when
//     is_signed=1, otherwise the value unchanged (w <= MAX_W)
package shift_add_mul_pkg;

    localparam int STATE_W = 2;
    localparam int MAX_W   = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x holds a w-bit value zero-extended to MAX_W bits. The result is
    // masked back to w bits, so the most negative value maps onto
    // 2^(w-1), which still fits as an unsigned w-bit number.
    function automatic logic [MAX_W-1:0] magnitude(
        input logic [MAX_W-1:0] x,
        input int unsigned      w,
        input logic             is_signed
    );
        logic [MAX_W-1:0] mask;
        logic             sign;
        mask = (64'd1 << w) - 64'd1;
        sign = |(x & (64'd1 << (w - 1)));
        if (is_signed && sign) begin
            return (~x + 64'd1) & mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/shift_add_mul_dp.sv
// Datapath of the shift-and-add multiplier.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_load              : capture |a|, |b|, sign and clear acc/cnt
//   i_step              : one shift-and-add iteration
//   i_commit            : write product (0 when coincident with i_load,
//                         otherwise the signed-corrected running sum)
//   i_signed_mode, i_a, i_b : operands, used only with i_load
//   o_b_zero            : |i_b| == 0 (combinational, for the early exit)
//   o_last              : current iteration is the final one
//   o_product           : registered 2*WIDTH result
module shift_add_mul_dp
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_commit,
    input  logic                 i_signed_mode,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_b_zero,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_sum;

    assign w_mag_a = WIDTH'(magnitude(64'(i_a), 32'(WIDTH), i_signed_mode));
    assign w_mag_b = WIDTH'(magnitude(64'(i_b), 32'(WIDTH), i_signed_mode));

    // Magnitudes are < 2^WIDTH each, so the accumulated sum always fits.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign o_b_zero  = (w_mag_b == '0);
    assign o_last    = ((EARLY_TERM != 0) && ((r_mplier >> 1) == '0)) ||
                       (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_neg    <= i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // A commit together with a load is the zero-multiplier shortcut: the
    // running registers still hold the previous operation, so write 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (i_commit) begin
            r_product <= i_load ? '0 : (r_neg ? -w_sum : w_sum);
        end
    end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential radix-2 shift-and-add multiplier, signed or unsigned.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : request, accepted only on an edge where ready=1
//   signed_mode,a,b  : operands, sampled on the accepting edge only
//   ready            : idle, able to accept start
//   busy             : iterating
//   done             : one-cycle pulse, product valid from this cycle on
//   product          : 2*WIDTH result, held until the next completion
//   dbg_state        : current FSM state
// Handshake: a request is taken on a rising edge where start=1 and
// ready=1; start is ignored at all other times without side effects.
// Exactly one done pulse follows every accepted request, and ready only
// returns in the cycle after done.
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int EARLY_TERM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output state_t             dbg_state
);

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_step;
    logic   w_commit;
    logic   w_b_zero;
    logic   w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if ((EARLY_TERM != 0) && w_b_zero) begin
                        w_commit = 1'b1;
                        w_next   = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_commit = 1'b1;
                    w_next   = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign ready     = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    shift_add_mul_dp #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_commit      (w_commit),
        .i_signed_mode (signed_mode),
        .i_a           (a),
        .i_b           (b),
        .o_b_zero      (w_b_zero),
        .o_last        (w_last),
        .o_product     (product)
    );

endmodule
